// File: rtl/sensemi_rst_pkg.sv
// sensemi_rst_pkg: shared state type and default timing for the reset sequencer
package sensemi_rst_pkg;
   typedef enum logic [1:0] {HOLD, PERIPH, RUN} rst_state_t;
   localparam int POR_CYCLES_DEF      = 1024;
   localparam int STAGE_GAP_DEF       = 64;
   localparam int DEBOUNCE_CYCLES_DEF = 100000;
   localparam int SYNC_STAGES_DEF     = 2;
   function automatic int max2(input int a, input int b);
      return a > b ? a : b;
   endfunction
endpackage

// File: rtl/sensemi_rst_seq_if.sv
// sensemi_rst_seq_if: board-side inputs and staged reset outputs of the sequencer
interface sensemi_rst_seq_if;
   logic       i_btn_rst_n;
   logic       i_pll_locked;
   logic       o_rst_periph;
   logic       o_rst_core;
   logic       o_rst_done;
   logic [1:0] o_state;
   modport master (output i_btn_rst_n, i_pll_locked, input o_rst_periph, o_rst_core, o_rst_done, o_state);
   modport slave  (input i_btn_rst_n, i_pll_locked, output o_rst_periph, o_rst_core, o_rst_done, o_state);
endinterface

// File: rtl/sensemi_cdc_sync.sv
// sensemi_cdc_sync: multi-flop level synchronizer with a selectable reset value
module sensemi_cdc_sync #(
   parameter int   SYNC_STAGES = 2,
   parameter logic RST_VAL     = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic d_i,
   output logic q_o
);
   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   assign sync_d = {sync_q[SYNC_STAGES-2:0], d_i};
   // shift the asynchronous level one flop deeper each cycle
   always_ff @(posedge clk) sync_q <= rst ? {SYNC_STAGES{RST_VAL}} : sync_d;
   assign q_o = sync_q[SYNC_STAGES-1];
endmodule

// File: rtl/sensemi_rst_seq.sv
// sensemi_rst_seq: staged reset release gated by PLL lock and a debounced push-button
module sensemi_rst_seq
   import sensemi_rst_pkg::*;
#(
   parameter int POR_CYCLES      = POR_CYCLES_DEF,
   parameter int STAGE_GAP       = STAGE_GAP_DEF,
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
   parameter int SYNC_STAGES     = SYNC_STAGES_DEF
) (
   input logic              i_fpga_clk,
   input logic              i_rst,
   sensemi_rst_seq_if.slave bus
);
   localparam int CW = $clog2(max2(POR_CYCLES, STAGE_GAP));
   localparam int DW = $clog2(DEBOUNCE_CYCLES);
   logic          btn_s, lock_s, fault, flip;
   logic          db_q, db_d;
   logic [DW-1:0] dbc_q, dbc_d;
   logic [CW-1:0] cnt_q, cnt_d;
   rst_state_t    st_q, st_d;
   logic          periph_q, core_q, done_q;

   sensemi_cdc_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_btn_sync (
      .clk(i_fpga_clk), .rst(i_rst), .d_i(bus.i_btn_rst_n), .q_o(btn_s));
   sensemi_cdc_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_lock_sync (
      .clk(i_fpga_clk), .rst(i_rst), .d_i(bus.i_pll_locked), .q_o(lock_s));

   // a new button level is accepted only after it has been seen for DEBOUNCE_CYCLES samples in a row
   assign flip  = (btn_s != db_q) && (dbc_q == DW'(DEBOUNCE_CYCLES - 1));
   assign dbc_d = (btn_s == db_q || flip) ? '0 : dbc_q + 1'b1;
   assign db_d  = flip ? btn_s : db_q;
   assign fault = !db_q || !lock_s;

   // next state: fault always wins and restarts the count from zero
   always_comb begin
      st_d  = st_q;
      cnt_d = '0;
      if (fault) st_d = HOLD;
      else
         case (st_q)
            HOLD:    if (cnt_q == CW'(POR_CYCLES - 1)) st_d = PERIPH; else cnt_d = cnt_q + 1'b1;
            PERIPH:  if (cnt_q == CW'(STAGE_GAP - 1)) st_d = RUN; else cnt_d = cnt_q + 1'b1;
            RUN:     st_d = RUN;
            default: st_d = HOLD;
         endcase
   end

   // state, counters and reset outputs; outputs decode the next state so they move with o_state
   always_ff @(posedge i_fpga_clk) begin
      if (i_rst) begin
         st_q     <= HOLD;
         cnt_q    <= '0;
         db_q     <= 1'b1;
         dbc_q    <= '0;
         periph_q <= 1'b1;
         core_q   <= 1'b1;
         done_q   <= 1'b0;
      end else begin
         st_q     <= st_d;
         cnt_q    <= cnt_d;
         db_q     <= db_d;
         dbc_q    <= dbc_d;
         periph_q <= st_d == HOLD;
         core_q   <= st_d != RUN;
         done_q   <= st_d == RUN;
      end
   end

   assign bus.o_rst_periph = periph_q;
   assign bus.o_rst_core   = core_q;
   assign bus.o_rst_done   = done_q;
   assign bus.o_state      = st_q;
endmodule

// File: tb/tb_sensemi_rst_seq.sv
// tb_sensemi_rst_seq: directed and randomized checks of the reset sequencer against a behavioural model
module tb_sensemi_rst_seq;
   localparam int POR = 16, GAP = 4, DEB = 8, SS = 2;
   logic clk = 1'b0, rst = 1'b1;
   int   tests = 0, fails = 0;

   sensemi_rst_seq_if ifc();
   sensemi_rst_seq #(.POR_CYCLES(POR), .STAGE_GAP(GAP), .DEBOUNCE_CYCLES(DEB), .SYNC_STAGES(SS)) dut (
      .i_fpga_clk(clk), .i_rst(rst), .bus(ifc));

   always #5 clk = ~clk;

   // model: inputs seen through an SS-deep delay line, button accepted after DEB identical
   // samples, and the sequence position is just the length of the current fault-free run
   bit bh[SS], lh[SS], win[DEB];
   bit db_m, valid;
   int n_m;

   function automatic int mst();
      return n_m >= POR + GAP ? 2 : (n_m >= POR ? 1 : 0);
   endfunction

   function automatic int mexp();
      int s;
      s = mst();
      return (s == 0 ? 16 : 0) + (s != 2 ? 8 : 0) + (s == 2 ? 4 : 0) + s;
   endfunction

   function automatic int outs();
      return int'({ifc.o_rst_periph, ifc.o_rst_core, ifc.o_rst_done, ifc.o_state});
   endfunction

   function automatic void chk(input string nm, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
      end
   endfunction

   always @(posedge clk) begin
      bit sb, sl, fault, flip;
      if (rst) begin
         foreach (bh[i]) bh[i] = 1'b1;
         foreach (lh[i]) lh[i] = 1'b0;
         foreach (win[i]) win[i] = 1'b1;
         db_m  = 1'b1;
         n_m   = 0;
         valid = 1'b1;
      end else if (valid) begin
         sb    = bh[SS-1];
         sl    = lh[SS-1];
         fault = !db_m || !sl;
         for (int i = SS - 1; i > 0; i--) begin
            bh[i] = bh[i-1];
            lh[i] = lh[i-1];
         end
         bh[0] = ifc.i_btn_rst_n;
         lh[0] = ifc.i_pll_locked;
         for (int i = DEB - 1; i > 0; i--) win[i] = win[i-1];
         win[0] = sb;
         flip = 1'b1;
         foreach (win[i]) if (win[i] == db_m) flip = 1'b0;
         if (flip) db_m = !db_m;
         n_m = fault ? 0 : (n_m < POR + GAP ? n_m + 1 : n_m);
      end
   end

   always @(negedge clk) if (valid) chk("cycle", outs(), mexp());

   task automatic step(input int k);
      repeat (k) @(negedge clk);
   endtask

   task automatic lit(input string nm, input int st);
      chk({nm, "_dut"}, int'(ifc.o_state), st);
      chk({nm, "_mdl"}, mst(), st);
   endtask

   initial begin
      ifc.i_btn_rst_n  = 1'b1;
      ifc.i_pll_locked = 1'b1;
      step(1);
      chk("rst_outs", outs(), 5'b11000);
      step(4);
      rst = 1'b0;
      step(17); lit("pwr17", 0); chk("pwr17_periph", int'(ifc.o_rst_periph), 1);
      step(1);  lit("pwr18", 1); chk("pwr18_periph", int'(ifc.o_rst_periph), 0);
      chk("pwr18_core", int'(ifc.o_rst_core), 1);
      step(3);  lit("pwr21", 1);
      step(1);  lit("pwr22", 2); chk("pwr22_done", int'(ifc.o_rst_done), 1);
      chk("pwr22_core", int'(ifc.o_rst_core), 0);
      step(3);
      ifc.i_pll_locked = 1'b0; step(1); ifc.i_pll_locked = 1'b1;
      step(1);  lit("lk_g1", 2);
      step(1);  lit("lk_g2", 0); chk("lk_g2_outs", outs(), 5'b11000);
      step(16); lit("lk_g18", 1);
      step(3);  lit("lk_g21", 1);
      step(1);  lit("lk_g22", 2);
      step(3);
      ifc.i_btn_rst_n = 1'b0; step(5); ifc.i_btn_rst_n = 1'b1;
      step(12); lit("glitch", 2); chk("glitch_done", int'(ifc.o_rst_done), 1);
      step(2);
      ifc.i_btn_rst_n = 1'b0; step(8); ifc.i_btn_rst_n = 1'b1;
      step(2);  lit("btn_h9", 2);
      step(1);  lit("btn_h10", 0); chk("btn_h10_periph", int'(ifc.o_rst_periph), 1);
      step(22); lit("btn_h32", 0);
      step(1);  lit("btn_h33", 1);
      step(4);  lit("btn_h37", 2);
      step(3);
      rst = 1'b1; step(1); rst = 1'b0;
      step(15);
      ifc.i_pll_locked = 1'b0; step(1); ifc.i_pll_locked = 1'b1;
      step(2);  lit("lk15_f18", 0); chk("lk15_periph", int'(ifc.o_rst_periph), 1);
      step(15); lit("lk15_f33", 0);
      step(1);  lit("lk15_f34", 1);
      rst = 1'b1; step(1);
      chk("rst_periph_outs", outs(), 5'b11000); lit("rst_periph", 0);
      rst = 1'b0;
      for (int s = 0; s < 150; s++) begin
         step($urandom_range(30, 0));
         case ($urandom_range(5, 0))
            0: begin ifc.i_pll_locked = 1'b0; step($urandom_range(3, 1)); ifc.i_pll_locked = 1'b1; end
            1, 2: begin ifc.i_btn_rst_n = 1'b0; step($urandom_range(12, 1)); ifc.i_btn_rst_n = 1'b1; end
            3: begin rst = 1'b1; step(1); rst = 1'b0; end
            4: begin
               repeat (10) begin ifc.i_btn_rst_n = 1'($urandom_range(1, 0)); step(1); end
               ifc.i_btn_rst_n = 1'b1;
            end
            default: step($urandom_range(40, 10));
         endcase
      end
      step(5);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/sensemi_rst_seq.md
Name: sensemi_rst_seq

Overview:
- Reset sequencer that sits directly downstream of the board-level differential clock buffer.
- Runs on the buffered i_fpga_clk, combines PLL/MMCM lock and the push-button reset, and drives staged resets into the rest of the prototype top.
- Release order: peripherals first, then the core, then o_rst_done.
- Any lock loss or debounced button press re-enters the hold state.

Parameters:
- POR_CYCLES, 1024: cycles of fault-free hold before o_rst_periph releases (>=2).
- STAGE_GAP, 64: cycles between o_rst_periph release and o_rst_core release (>=2).
- DEBOUNCE_CYCLES, 100000: consecutive stable cycles required to accept a new button level (>=2).
- SYNC_STAGES, 2: flop depth of each input synchronizer (>=2).

Ports:
- i_fpga_clk  input  1  buffered system clock; the only clock.
- i_rst  input  1  synchronous, active-high reset.
- i_btn_rst_n  input  1  asynchronous push-button, active-low, bouncy.
- i_pll_locked  input  1  asynchronous lock indicator, active-high.
- o_rst_periph  output  1  active-high peripheral reset.
- o_rst_core  output  1  active-high core reset.
- o_rst_done  output  1  high when the sequence is complete.
- o_state  output  2  current FSM state, for debug/ILA.

Behaviour:
- Reset (i_rst=1 at a clock edge), all registers synchronous:
  - o_rst_periph=1, o_rst_core=1, o_rst_done=0, o_state=HOLD.
  - Counter=0, debounce counter=0.
  - Button synchronizer flops=1 and debounced button=1 (released).
  - Lock synchronizer flops=0.
- Synchronizers: SYNC_STAGES-flop chains on i_btn_rst_n and i_pll_locked. Added latency is SYNC_STAGES cycles.
- Debounce (button only):
  - Debounce counter clears whenever the synced level differs from the debounced level's candidate.
  - The debounced level takes the new value when the synced level has held the new value for DEBOUNCE_CYCLES consecutive cycles.
  - Pulses shorter than DEBOUNCE_CYCLES have no effect.
- Lock loss is not debounced.
- fault = (debounced button == 0) OR (synced lock == 0).
- FSM states: HOLD=0, PERIPH=1, RUN=2. Encoding 3 is unused and recovers to HOLD.
  - HOLD:
    - Fault: counter stays 0.
    - No fault: counter increments.
    - When counter==POR_CYCLES-1 with no fault: go to PERIPH and clear counter.
  - PERIPH:
    - Counter increments.
    - When counter==STAGE_GAP-1: go to RUN and clear counter.
  - RUN: holds until fault.
  - Any state with fault: next state HOLD and counter cleared. Fault has priority over the terminal count in the same cycle.
- Outputs are registered and decoded from the next state, so they change in the same edge as o_state:
  - o_rst_periph = (state==HOLD).
  - o_rst_core = (state!=RUN).
  - o_rst_done = (state==RUN).
- Timing:
  - o_rst_periph falls exactly POR_CYCLES cycles after the first fault-free cycle in HOLD.
  - o_rst_core and o_rst_done fall/rise exactly STAGE_GAP cycles later.
- Fault while in PERIPH or RUN: both resets reassert on the next edge, o_rst_done drops, and the full sequence restarts after the fault clears.
- Button held low: stays in HOLD indefinitely. Release must also pass debounce before the counting restarts.
- i_rst asserted mid-sequence returns everything to reset values on the next edge.
- Counter width = $clog2(max(POR_CYCLES, STAGE_GAP)). Debounce counter width = $clog2(DEBOUNCE_CYCLES). Neither counter wraps; both compare with equality to terminal.

Decomposition:
- Package sensemi_rst_pkg holds:
  - typedef enum logic [1:0] rst_state_t {HOLD, PERIPH, RUN};
  - default localparams for POR_CYCLES, STAGE_GAP, DEBOUNCE_CYCLES.
- One sub-module, sensemi_cdc_sync:
  - parameters SYNC_STAGES and RST_VAL; synchronous reset.
  - Instantiated twice, once per asynchronous input.
- Debounce and FSM stay inline in sensemi_rst_seq.

Test Plan (POR_CYCLES=16, STAGE_GAP=4, DEBOUNCE_CYCLES=8, SYNC_STAGES=2):
- Power-up: i_rst high for 5 cycles, then low, with lock=1 and btn=1.
  - o_rst_periph falls 16 cycles after the first fault-free cycle.
  - o_rst_core falls and o_rst_done rises 4 cycles after that.
  - o_state goes 0→1→2.
- Lock drops for 1 cycle while in RUN.
  - After the 2-cycle sync delay: both resets=1, done=0, state=0.
  - Full 16+4 sequence repeats after lock returns.
- Button glitch low for 5 cycles while in RUN.
  - No output change.
- Button held low for 8 cycles.
  - Resets assert 2+8 cycles after the falling edge.
  - Release must be stable 8 cycles before HOLD counting resumes.
- Lock lost on the exact cycle counter==15 in HOLD.
  - Stays in HOLD with counter=0; o_rst_periph never deasserts.
- i_rst pulsed 1 cycle in PERIPH.
  - Next edge returns reset values: o_rst_periph=1, o_state=0.
